pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage RISC-V pipeline. Merges every hazard source (load-use, taken-branch redirect, multi-cycle mul/div occupancy in EX, data-memory wait) into one prioritized set of per-stage write-enable and flush strobes. It also counts stall cycles for performance monitoring. Sits beside the pipeline registers and drives PC, IF/ID, ID/EX and EX/MEM control directly.

## Interface
- MULDIV_TIMEOUT, 64: max cycles in MULDIV before abort (≥2).
- CNT_W, 16: stall-cycle counter width.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- if_id_rs1, if_id_rs2  in  5 each  source registers of instruction in ID.
- if_id_use_rs1, if_id_use_rs2  in  1 each  ID instruction actually reads that source.
- id_ex_rd  in  5  destination of instruction in EX.
- id_ex_memread  in  1  instruction in EX is a load.
- ex_redirect  in  1  branch/jump in EX resolved taken; PC is being redirected.
- ex_muldiv_start  in  1  mul/div instruction present in EX this cycle (first cycle).
- muldiv_done  in  1  mul/div result valid this cycle.
- dmem_wait  in  1  data memory not ready; MEM access must hold.
- stall_cnt_clr  in  1  synchronous clear of stall_cycles.
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  stage register load enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (NOP) into that register.
- stall  out  1  front end held this cycle (= reset deasserted and pc_write==0).
- stall_cycles  out  CNT_W  saturating count of stall cycles.
- timeout_err  out  1  sticky: mul/div exceeded MULDIV_TIMEOUT.

## Operation
- State register: RUN, MULDIV. Timeout counter tmo (width ceil(log2(MULDIV_TIMEOUT+1))).
- Default (no hazard): all *_write=1, all *_flush=0.
- Load-use hit = id_ex_memread && id_ex_rd!=0 && ((use_rs1 && rs1==rd) || (use_rs2 && rs2==rd)). x0 never matches.
- Priority, highest first, evaluated every cycle:
  1. dmem_wait=1: all *_write=0, all *_flush=0 (full freeze). State, tmo do not advance. Lower hazards are deferred.
  2. MULDIV stall, i.e. (state==MULDIV or ex_muldiv_start) and muldiv_done=0: pc/if_id/id_ex_write=0, ex_mem_write=1, ex_mem_flush=1.
  3. ex_redirect: pc_write=1, if_id_flush=1, id_ex_flush=1, other writes 1.
  4. Load-use hit: pc_write=0, if_id_write=0, id_ex_flush=1 (id_ex_write=1), ex_mem_write=1.
- Transitions (only when dmem_wait=0):
  - RUN→MULDIV: ex_muldiv_start=1 and muldiv_done=0; tmo←1.
  - Single-cycle op (start and done same cycle): stay RUN, no stall.
  - MULDIV→RUN: muldiv_done=1. That cycle evaluates as RUN with ex_muldiv_start ignored.
  - MULDIV→RUN on tmo==MULDIV_TIMEOUT. timeout_err←1 (sticky until reset). That cycle behaves as done.
  - Otherwise in MULDIV: tmo←tmo+1.
- ex_redirect together with MULDIV stall is illegal; rule 2 wins. The bench flags it.
- stall_cycles: +1 on each cycle with stall=1, saturates at 2^CNT_W−1. stall_cnt_clr has priority over increment (result 0).

## Timing
- Reset asserted (async): state=RUN, tmo=0, stall_cycles=0, timeout_err=0.
  - While asserted: all *_write=0, all *_flush=0, stall=0.
- Strobe outputs are combinational from current inputs and state; zero-cycle latency, no registered delay.
- State, tmo, stall_cycles, timeout_err update on rising clock edge.
- Load-use costs exactly 1 stall cycle. The bubble in ID/EX clears the hit on the next cycle.
- Mul/div with done N cycles after start costs N stall cycles.
- Reset asserted mid-MULDIV: immediate return to RUN, counters cleared, outputs forced to reset values.
- Counter saturation and clear are evaluated in the same edge as the stall it would count.

## Test plan
- Load-use: memread=1, rd=5, rs1=5, use_rs1=1 → one cycle pc_write=0, if_id_write=0, id_ex_flush=1, stall=1. Next cycle (memread=0) all writes=1, stall_cycles=1.
- x0 / unused source: rd=0, rs1=0; or rd=7, rs2=7, use_rs2=0 → no stall.
- Mul/div: start at cycle 0, done at cycle 4 → cycles 0–3 pc/if_id/id_ex_write=0 and ex_mem_flush=1. Cycle 4 all writes=1; stall_cycles=4.
- Priority: dmem_wait=1 with load-use hit and redirect → all writes 0, no flushes. Drop dmem_wait → redirect flushes IF/ID and ID/EX, no load-use stall.
- Timeout: MULDIV_TIMEOUT=8, done never asserted → exit MULDIV after tmo reaches 8, timeout_err=1. It stays 1 until reset=0.
- Reset mid-MULDIV and saturation: reset low 3 cycles mid-stall → outputs 0, state RUN. With CNT_W=4, 20 stall cycles → stall_cycles=15; stall_cnt_clr → 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: merges dmem wait, mul/div occupancy, EX redirect and load-use into per-stage strobes.
// Strobes are combinational (zero latency); state, timeout and stall counter update on the rising clock edge.
module pipeline_hazard_ctrl #(
   parameter int MULDIV_TIMEOUT = 64,
   parameter int CNT_W          = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       if_id_rs1,
   input  logic [4:0]       if_id_rs2,
   input  logic             if_id_use_rs1,
   input  logic             if_id_use_rs2,
   input  logic [4:0]       id_ex_rd,
   input  logic             id_ex_memread,
   input  logic             ex_redirect,
   input  logic             ex_muldiv_start,
   input  logic             muldiv_done,
   input  logic             dmem_wait,
   input  logic             stall_cnt_clr,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             ex_mem_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             timeout_err
);

   localparam int               TMO_W   = $clog2(MULDIV_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MULDIV_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic {RUN, MULDIV} state_t;

   state_t           state, state_nxt;
   logic [TMO_W-1:0] tmo, tmo_nxt;
   logic             terr_nxt;
   logic             load_use;
   logic             md_stall;

   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   assign load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                     ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
                      (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= RUN;
         tmo         <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         tmo         <= tmo_nxt;
         timeout_err <= terr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      tmo_nxt      = tmo;
      terr_nxt     = timeout_err;
      md_stall     = 1'b0;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;

      if (!reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
      end else if (dmem_wait) begin
         // Full freeze: every lower-priority hazard is deferred until memory answers.
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (ex_muldiv_start && !muldiv_done) begin
                  md_stall  = 1'b1;
                  state_nxt = MULDIV;
                  tmo_nxt   = TMO_W'(1);
               end
            end
            MULDIV: begin
               // The exit cycle evaluates as RUN; the start strobe is stale here.
               if (muldiv_done) begin
                  state_nxt = RUN;
                  tmo_nxt   = '0;
               end else if (tmo == TMO_MAX) begin
                  state_nxt = RUN;
                  tmo_nxt   = '0;
                  terr_nxt  = 1'b1;
               end else begin
                  md_stall = 1'b1;
                  tmo_nxt  = tmo + TMO_W'(1);
               end
            end
            default: begin
               state_nxt = RUN;
               tmo_nxt   = '0;
            end
         endcase

         if (md_stall) begin
            // Hold the front end, drain EX/MEM with bubbles while the unit runs.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
         end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
         end
      end
   end

   assign stall = reset && !pc_write;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
      end else if (stall_cnt_clr) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != CNT_MAX)) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

   // {pc_w, if_id_w, id_ex_w, ex_mem_w, if_id_f, id_ex_f, ex_mem_f, stall}
   localparam logic [7:0] RST  = 8'b0000_000_0;
   localparam logic [7:0] NORM = 8'b1111_000_0;
   localparam logic [7:0] FRZ  = 8'b0000_000_1;
   localparam logic [7:0] MD   = 8'b0001_001_1;
   localparam logic [7:0] RED  = 8'b1111_110_0;
   localparam logic [7:0] LU   = 8'b0011_010_1;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] if_id_rs1 = '0, if_id_rs2 = '0, id_ex_rd = '0;
   logic       if_id_use_rs1 = 1'b0, if_id_use_rs2 = 1'b0, id_ex_memread = 1'b0;
   logic       ex_redirect = 1'b0, ex_muldiv_start = 1'b0, muldiv_done = 1'b0;
   logic       dmem_wait = 1'b0, stall_cnt_clr = 1'b0;
   logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
   logic       if_id_flush, id_ex_flush, ex_mem_flush, stall;
   logic [3:0] stall_cycles;
   logic       timeout_err;

   // staged inputs, applied just after the next rising edge
   logic       s_rst;
   logic [4:0] s_rs1, s_rs2, s_rd;
   logic       s_u1, s_u2, s_mr, s_red, s_ms, s_md, s_dw, s_clr;

   typedef struct {
      logic [7:0] strb;
      logic [3:0] cnt;
      logic       terr;
      int         id;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   step_no = 0;

   pipeline_hazard_ctrl #(.MULDIV_TIMEOUT(8), .CNT_W(4)) dut (
      .clock(clock), .reset(reset),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
      .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
      .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
      .ex_redirect(ex_redirect), .ex_muldiv_start(ex_muldiv_start),
      .muldiv_done(muldiv_done), .dmem_wait(dmem_wait), .stall_cnt_clr(stall_cnt_clr),
      .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
      .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .stall(stall), .stall_cycles(stall_cycles),
      .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   task automatic idle();
      s_rst = 1'b1; s_rs1 = '0; s_rs2 = '0; s_rd = '0;
      s_u1 = 1'b0; s_u2 = 1'b0; s_mr = 1'b0; s_red = 1'b0;
      s_ms = 1'b0; s_md = 1'b0; s_dw = 1'b0; s_clr = 1'b0;
   endtask

   task automatic step(input logic [7:0] es, input logic [3:0] ec, input logic et);
      exp_t e;
      @(posedge clock);
      #1;
      reset = s_rst; if_id_rs1 = s_rs1; if_id_rs2 = s_rs2; id_ex_rd = s_rd;
      if_id_use_rs1 = s_u1; if_id_use_rs2 = s_u2; id_ex_memread = s_mr;
      ex_redirect = s_red; ex_muldiv_start = s_ms; muldiv_done = s_md;
      dmem_wait = s_dw; stall_cnt_clr = s_clr;
      e.strb = es; e.cnt = ec; e.terr = et; e.id = step_no;
      sb.push_back(e);
      step_no++;
   endtask

   always @(negedge clock) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [7:0] act;
         e   = sb.pop_front();
         act = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                if_id_flush, id_ex_flush, ex_mem_flush, stall};
         n_tests += 3;
         if (act !== e.strb) begin
            n_fail++;
            $display("FAIL strobes step %0d: got %b expected %b", e.id, act, e.strb);
         end
         if (stall_cycles !== e.cnt) begin
            n_fail++;
            $display("FAIL stall_cycles step %0d: got %0d expected %0d", e.id, stall_cycles, e.cnt);
         end
         if (timeout_err !== e.terr) begin
            n_fail++;
            $display("FAIL timeout_err step %0d: got %b expected %b", e.id, timeout_err, e.terr);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      idle(); s_rst = 1'b0;
      step(RST, 0, 0);
      step(RST, 0, 0);
      idle(); step(NORM, 0, 0);

      // load-use on rs1: one bubble, then free
      idle(); s_mr = 1; s_rd = 5; s_rs1 = 5; s_u1 = 1; step(LU, 0, 0);
      idle(); s_rd = 5; s_rs1 = 5; s_u1 = 1;            step(NORM, 1, 0);
      // x0 and unused source never stall
      idle(); s_mr = 1; s_rd = 0; s_rs1 = 0; s_u1 = 1;  step(NORM, 1, 0);
      idle(); s_mr = 1; s_rd = 7; s_rs2 = 7;            step(NORM, 1, 0);
      // load-use on rs2
      idle(); s_mr = 1; s_rd = 7; s_rs2 = 7; s_u2 = 1;  step(LU, 1, 0);
      idle(); step(NORM, 2, 0);

      // mul/div: start at c0, done at c4 -> 4 stall cycles
      idle(); s_ms = 1; step(MD, 2, 0);
      idle(); step(MD, 3, 0);
      idle(); step(MD, 4, 0);
      idle(); step(MD, 5, 0);
      idle(); s_md = 1; step(NORM, 6, 0);
      idle(); step(NORM, 6, 0);
      // single-cycle op
      idle(); s_ms = 1; s_md = 1; step(NORM, 6, 0);
      idle(); step(NORM, 6, 0);

      // priority: freeze beats redirect and load-use; then redirect beats load-use
      idle(); s_dw = 1; s_red = 1; s_mr = 1; s_rd = 5; s_rs1 = 5; s_u1 = 1; step(FRZ, 6, 0);
      idle(); s_red = 1; s_mr = 1; s_rd = 5; s_rs1 = 5; s_u1 = 1;           step(RED, 7, 0);
      idle(); step(NORM, 7, 0);

      // freeze holds MULDIV state; redirect during mul/div stall loses
      idle(); s_ms = 1;            step(MD, 7, 0);
      idle(); s_dw = 1; s_md = 1;  step(FRZ, 8, 0);
      idle(); s_red = 1;           step(MD, 9, 0);
      idle(); s_md = 1;            step(NORM, 10, 0);
      idle(); s_clr = 1;           step(NORM, 10, 0);
      idle();                      step(NORM, 0, 0);

      // timeout: done never comes, 8 stall cycles then exit with sticky error
      idle(); s_ms = 1; step(MD, 0, 0);
      for (int k = 1; k <= 7; k++) begin
         idle(); step(MD, 4'(k), 0);
      end
      idle(); step(NORM, 8, 0);
      idle(); step(NORM, 8, 1);
      idle(); s_clr = 1; step(NORM, 8, 1);
      idle(); step(NORM, 0, 1);

      // saturation over 20 stall cycles, then clear wins over increment
      for (int k = 0; k < 20; k++) begin
         idle(); s_dw = 1; step(FRZ, (k > 15) ? 4'd15 : 4'(k), 1);
      end
      idle(); step(NORM, 15, 1);
      idle(); s_dw = 1; s_clr = 1; step(FRZ, 15, 1);
      idle(); step(NORM, 0, 1);

      // reset mid-MULDIV for 3 cycles
      idle(); s_ms = 1; step(MD, 0, 1);
      idle(); step(MD, 1, 1);
      for (int k = 0; k < 3; k++) begin
         idle(); s_rst = 1'b0; s_md = 1; step(RST, 0, 0);
      end
      idle(); step(NORM, 0, 0);

      @(posedge clock);
      @(negedge clock);
      #1;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
